// File: rtl/serout_tx.sv
// rtl/serout_tx.sv - serial output transmitter: holding register, shifter and frame state machine.
// All state other than reset advances only on enn cycles; sod and sodBusy are registered every clk.
module serout_tx #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enn,
  input  logic       addrDw,
  input  logic [7:0] Din,
  input  logic       bitTick,
  input  logic       forceBreak,
  output logic       sod,
  output logic       sodBusy,
  output logic       outNeeded,
  output logic       outDone
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t     state, state_n;
  logic [7:0] hold, hold_n;
  logic [7:0] shift, shift_n;
  logic       hold_full, hold_full_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       stop_cnt, stop_cnt_n;
  logic       xfer;
  logic       line_n;

  always_comb begin
    state_n     = state;
    hold_n      = hold;
    shift_n     = shift;
    hold_full_n = hold_full;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    xfer        = 1'b0;
    if (enn) begin
      case (state)
        IDLE:  if (hold_full) xfer = 1'b1;
        START: if (bitTick) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
        end
        DATA:  if (bitTick) begin
          if (bit_cnt == 3'd7) begin
            state_n    = STOP;
            stop_cnt_n = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
          end
        end
        STOP:  if (bitTick) begin
          if (stop_cnt == LAST_STOP) begin
            // A pending byte chains straight into the next start bit.
            if (hold_full) xfer = 1'b1;
            else           state_n = IDLE;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      if (xfer) begin
        shift_n     = hold;
        hold_full_n = 1'b0;
        state_n     = START;
        bit_cnt_n   = 3'd0;
      end
      // A write on the transfer cycle lands after the shifter took the old byte.
      if (addrDw) begin
        hold_n      = Din;
        hold_full_n = 1'b1;
      end
    end
  end

  always_comb begin
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      hold      <= 8'h00;
      shift     <= 8'h00;
      hold_full <= 1'b0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 1'b0;
      sod       <= 1'b1;
      sodBusy   <= 1'b0;
      outNeeded <= 1'b0;
      outDone   <= 1'b1;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      shift     <= shift_n;
      hold_full <= hold_full_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      sod       <= line_n & ~forceBreak;
      sodBusy   <= (state != IDLE);
      if (enn) begin
        outNeeded <= xfer;
        outDone   <= (state == IDLE) && !hold_full;
      end
    end
  end

endmodule

// File: tb/tb_serout_tx.sv
// tb/tb_serout_tx.sv - self-checking bench for serout_tx with a per-bit scoreboard.
module tb_serout_tx;

  localparam int ENN_DIV  = 4;
  localparam int TICK_DIV = 16;
  localparam int FRAME_MAX = 3000;

  logic       clk = 1'b0;
  logic       resetN, enn, addrDw, bitTick, forceBreak;
  logic [7:0] Din;
  logic       sod, sodBusy, outNeeded, outDone;
  logic       resetN2, addrDw2;
  logic [7:0] Din2;
  logic       sod2, sodBusy2, outNeeded2, outDone2;

  int tests  = 0;
  int failed = 0;
  bit exp_q[$];
  bit exp_q2[$];
  bit e1, e2;
  int need_cnt = 0;
  int need_len = 0;
  int ecnt     = 0;
  bit watch = 1'b0, seen_done = 1'b0, seen_idle = 1'b0;

  always #10 clk = ~clk;

  serout_tx #(.STOP_BITS(1)) dut (
    .clk(clk), .resetN(resetN), .enn(enn), .addrDw(addrDw), .Din(Din),
    .bitTick(bitTick), .forceBreak(forceBreak), .sod(sod), .sodBusy(sodBusy),
    .outNeeded(outNeeded), .outDone(outDone)
  );

  serout_tx #(.STOP_BITS(2)) dut2 (
    .clk(clk), .resetN(resetN2), .enn(enn), .addrDw(addrDw2), .Din(Din2),
    .bitTick(bitTick), .forceBreak(1'b0), .sod(sod2), .sodBusy(sodBusy2),
    .outNeeded(outNeeded2), .outDone(outDone2)
  );

  // enn every ENN_DIV clks, bitTick on every TICK_DIV-th enn cycle
  initial begin
    enn = 1'b0;
    bitTick = 1'b0;
    forever begin
      repeat (ENN_DIV - 1) begin
        @(posedge clk);
        #1 enn = 1'b0;
        bitTick = 1'b0;
      end
      @(posedge clk);
      #1 enn = 1'b1;
      bitTick = (ecnt == TICK_DIV - 1);
      ecnt = (ecnt == TICK_DIV - 1) ? 0 : ecnt + 1;
    end
  end

  // At the negedge before a tick edge, sod still holds the bit that tick closes.
  always @(negedge clk) begin
    if (enn && bitTick && sodBusy) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL sod_unexpected_bit: sod=%0b, no frame bit expected", sod);
      end else begin
        e1 = exp_q.pop_front();
        if (sod !== e1) begin
          failed++;
          $display("FAIL sod_bit: sod=%0b expected %0b", sod, e1);
        end
      end
    end
    if (enn && bitTick && sodBusy2) begin
      tests++;
      if (exp_q2.size() == 0) begin
        failed++;
        $display("FAIL sod2_unexpected_bit: sod2=%0b, no frame bit expected", sod2);
      end else begin
        e2 = exp_q2.pop_front();
        if (sod2 !== e2) begin
          failed++;
          $display("FAIL sod2_bit: sod2=%0b expected %0b", sod2, e2);
        end
      end
    end
    if (outNeeded) begin
      if (need_len == 0) need_cnt++;
      need_len++;
    end else if (need_len != 0) begin
      tests++;
      if (need_len !== ENN_DIV) begin
        failed++;
        $display("FAIL outNeeded_width: %0d clks expected %0d", need_len, ENN_DIV);
      end
      need_len = 0;
    end
    if (watch) begin
      if (outDone)  seen_done = 1'b1;
      if (!sodBusy) seen_idle = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [7:0] d, input bit brk, input bit second);
    if (second) exp_q2.push_back(1'b0); else exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (second) exp_q2.push_back(brk ? 1'b0 : d[i]);
      else        exp_q.push_back(brk ? 1'b0 : d[i]);
    end
    for (int i = 0; i < (second ? 2 : 1); i++) begin
      if (second) exp_q2.push_back(!brk);
      else        exp_q.push_back(!brk);
    end
  endtask

  task automatic wait_enn(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (enn) k++;
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (enn && bitTick) k++;
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    addrDw = 1'b1;
    Din = d;
    do @(posedge clk); while (!enn);
    #2 addrDw = 1'b0;
  endtask

  task automatic write_byte2(input logic [7:0] d);
    @(negedge clk);
    addrDw2 = 1'b1;
    Din2 = d;
    do @(posedge clk); while (!enn);
    #2 addrDw2 = 1'b0;
  endtask

  task automatic wait_frames(input bit second, input int max_clks);
    int n = 0;
    while (((second ? exp_q2.size() : exp_q.size()) != 0 || (second ? sodBusy2 : sodBusy))
           && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= max_clks) begin
      failed++;
      $display("FAIL frame_timeout: %0d bits still pending after %0d clks",
               second ? exp_q2.size() : exp_q.size(), n);
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0; resetN2 = 1'b0;
    addrDw = 1'b0; addrDw2 = 1'b0; Din = 8'h00; Din2 = 8'h00; forceBreak = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({sod, sodBusy, outNeeded, outDone} !== 4'b1001) begin
      failed++;
      $display("FAIL reset_outputs: sod/busy/need/done=%b expected 1001",
               {sod, sodBusy, outNeeded, outDone});
    end
    tests++;
    if ({sod2, sodBusy2, outDone2} !== 3'b101) begin
      failed++;
      $display("FAIL reset_outputs2: sod/busy/done=%b expected 101", {sod2, sodBusy2, outDone2});
    end
    resetN = 1'b1; resetN2 = 1'b1;
    wait_enn(3);
    @(negedge clk);
    tests++;
    if ({outNeeded, sodBusy, sod} !== 3'b001 || need_cnt !== 0) begin
      failed++;
      $display("FAIL reset_exit_quiet: need/busy/sod=%b pulses=%0d expected 001 and 0",
               {outNeeded, sodBusy, sod}, need_cnt);
    end
  endtask

  task automatic test_single_frame;
    int n0 = need_cnt;
    tests++;
    if (outDone !== 1'b1) begin
      failed++;
      $display("FAIL single_done_before: outDone=%0b expected 1", outDone);
    end
    wait_ticks(1);
    push_frame(8'hA5, 1'b0, 1'b0);
    write_byte(8'hA5);
    wait_enn(2);
    @(negedge clk);
    tests++;
    if ({outDone, sodBusy, sod} !== 3'b010) begin
      failed++;
      $display("FAIL single_started: done/busy/sod=%b expected 010", {outDone, sodBusy, sod});
    end
    wait_frames(1'b0, FRAME_MAX);
    wait_enn(2);
    @(negedge clk);
    tests++;
    if ({outDone, sod} !== 2'b11 || need_cnt - n0 !== 1) begin
      failed++;
      $display("FAIL single_end: done/sod=%b pulses=%0d expected 11 and 1",
               {outDone, sod}, need_cnt - n0);
    end
  endtask

  task automatic test_back_to_back;
    int n0 = need_cnt;
    int n = 0;
    wait_ticks(1);
    push_frame(8'h3C, 1'b0, 1'b0);
    push_frame(8'hC3, 1'b0, 1'b0);
    write_byte(8'h3C);
    wait_enn(2);
    seen_done = 1'b0; seen_idle = 1'b0; watch = 1'b1;
    wait_ticks(3);
    write_byte(8'hC3);
    while (exp_q.size() != 0 && n < 2 * FRAME_MAX) begin
      @(negedge clk);
      n++;
    end
    watch = 1'b0;
    wait_frames(1'b0, FRAME_MAX);
    tests++;
    if (seen_done !== 1'b0 || seen_idle !== 1'b0) begin
      failed++;
      $display("FAIL b2b_continuous: outDone_seen=%0b idle_seen=%0b expected 0 0",
               seen_done, seen_idle);
    end
    tests++;
    if (need_cnt - n0 !== 2) begin
      failed++;
      $display("FAIL b2b_pulses: %0d expected 2", need_cnt - n0);
    end
  endtask

  task automatic test_overwrite;
    int n0 = need_cnt;
    wait_ticks(1);
    push_frame(8'h11, 1'b0, 1'b0);
    push_frame(8'h33, 1'b0, 1'b0);
    write_byte(8'h11);
    wait_ticks(3);
    write_byte(8'h22);
    wait_enn(3);
    write_byte(8'h33);
    wait_frames(1'b0, 2 * FRAME_MAX);
    wait_enn(2);
    @(negedge clk);
    tests++;
    if (need_cnt - n0 !== 2 || outDone !== 1'b1) begin
      failed++;
      $display("FAIL overwrite_end: pulses=%0d outDone=%0b expected 2 and 1",
               need_cnt - n0, outDone);
    end
  endtask

  task automatic test_break;
    @(negedge clk);
    forceBreak = 1'b1;
    @(negedge clk);
    tests++;
    if (sod !== 1'b0) begin
      failed++;
      $display("FAIL break_idle: sod=%0b expected 0", sod);
    end
    wait_ticks(1);
    push_frame(8'hFF, 1'b1, 1'b0);
    write_byte(8'hFF);
    wait_frames(1'b0, FRAME_MAX);
    wait_enn(2);
    @(negedge clk);
    tests++;
    if (sod !== 1'b0 || outDone !== 1'b1) begin
      failed++;
      $display("FAIL break_held: sod=%0b outDone=%0b expected 0 and 1", sod, outDone);
    end
    forceBreak = 1'b0;
    @(negedge clk);
    tests++;
    if (sod !== 1'b1 || outDone !== 1'b1) begin
      failed++;
      $display("FAIL break_release: sod=%0b outDone=%0b expected 1 and 1", sod, outDone);
    end
  endtask

  task automatic test_reset_midframe;
    int n0 = need_cnt;
    wait_ticks(1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    write_byte(8'h5A);
    wait_ticks(2);
    write_byte(8'h77);
    wait_ticks(3);
    wait_enn(4);
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    tests++;
    if ({sod, sodBusy, outDone} !== 3'b101) begin
      failed++;
      $display("FAIL midreset_outputs: sod/busy/done=%b expected 101", {sod, sodBusy, outDone});
    end
    tests++;
    if (exp_q.size() !== 0) begin
      failed++;
      $display("FAIL midreset_bits: %0d bits unsent expected 0", exp_q.size());
    end
    wait_ticks(3);
    @(negedge clk);
    tests++;
    if ({sod, sodBusy, outDone} !== 3'b101 || need_cnt - n0 !== 1) begin
      failed++;
      $display("FAIL midreset_quiet: sod/busy/done=%b pulses=%0d expected 101 and 1",
               {sod, sodBusy, outDone}, need_cnt - n0);
    end
  endtask

  task automatic test_two_stop_bits;
    wait_ticks(1);
    push_frame(8'h00, 1'b0, 1'b1);
    write_byte2(8'h00);
    wait_frames(1'b1, FRAME_MAX);
    wait_enn(2);
    @(negedge clk);
    tests++;
    if ({sod2, outDone2} !== 2'b11) begin
      failed++;
      $display("FAIL two_stop_end: sod2/done2=%b expected 11", {sod2, outDone2});
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overwrite;
    test_break;
    test_reset_midframe;
    test_two_stop_bits;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
